// File: rtl/bsg_serial_in_parallel_out_full.sv
// Serial-in, parallel-out gearbox: collects els_p words of width_p bits from a
// ready/valid input and presents them as one vector on a valid-then-yumi output.
// use_minimal_buffering_p=0 keeps a separate output buffer, so assembly of the
// next vector overlaps with the consumer holding the current one.
// use_minimal_buffering_p=1 assembles in place and stalls the input until yumi.
module bsg_serial_in_parallel_out_full #(
    parameter int width_p                 = -1,
    parameter int els_p                   = -1,
    parameter int hi_to_lo_p              = 0,
    parameter int use_minimal_buffering_p = 0
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            valid_i,
    input  logic [width_p-1:0]              data_i,
    output logic                            ready_o,
    output logic                            valid_o,
    output logic [els_p-1:0][width_p-1:0]   data_o,
    input  logic                            yumi_i
);

    localparam int cw_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [cw_lp-1:0] last_lp = cw_lp'(els_p - 1);

    logic [cw_lp-1:0] count_q, count_d, slot;
    logic             at_last, accept, final_accept;
    logic [els_p-1:0] slot_we;

    // With els_p==1 at_last is always true, so every accept is final and
    // the counter never leaves zero.
    assign at_last      = (count_q == last_lp);
    assign accept       = valid_i & ready_o;
    assign final_accept = accept & at_last;
    assign slot         = (hi_to_lo_p != 0) ? (last_lp - count_q) : count_q;

    // Next word position: advance on accept, wrap after the final word.
    always_comb begin
        count_d = count_q;
        if (accept) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
    end

    // Word counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    genvar gi;
    for (gi = 0; gi < els_p; gi++) begin : g_we
        assign slot_we[gi] = accept & (slot == cw_lp'(gi));
    end

    if (use_minimal_buffering_p == 0) begin : g_double
        logic [els_p-1:0][width_p-1:0] vec_d;
        logic [els_p-1:0][width_p-1:0] out_q;
        logic                          out_valid_q, out_valid_d;

        for (gi = 0; gi < els_p; gi++) begin : g_slot
            logic [width_p-1:0] word_q;
            // Assembly slot; storage is not reset, only the flags are.
            always_ff @(posedge clk_i) begin
                if (slot_we[gi]) word_q <= data_i;
            end
            // The incoming final word bypasses assembly straight into the vector.
            assign vec_d[gi] = slot_we[gi] ? data_i : word_q;
        end

        // Output buffer loads the completed vector on the final accept.
        always_ff @(posedge clk_i) begin
            if (final_accept) out_q <= vec_d;
        end

        // Output occupancy: a final accept wins over a simultaneous yumi.
        always_comb begin
            out_valid_d = out_valid_q;
            if (final_accept)  out_valid_d = 1'b1;
            else if (yumi_i)   out_valid_d = 1'b0;
        end

        // Output occupancy register.
        always_ff @(posedge clk_i) begin
            if (reset_i) out_valid_q <= 1'b0;
            else         out_valid_q <= out_valid_d;
        end

        // Only the final word needs a free output buffer; earlier words
        // land in assembly regardless of what the consumer is doing.
        assign ready_o = ~at_last | ~out_valid_q;
        assign valid_o = out_valid_q;
        assign data_o  = out_q;
    end else begin : g_single
        logic full_q, full_d;

        for (gi = 0; gi < els_p; gi++) begin : g_slot
            logic [width_p-1:0] word_q;
            // Shared slot; frozen while full because ready_o is low.
            always_ff @(posedge clk_i) begin
                if (slot_we[gi]) word_q <= data_i;
            end
            assign data_o[gi] = word_q;
        end

        // Full flag: set by the final accept, cleared by yumi.
        always_comb begin
            full_d = full_q;
            if (final_accept) full_d = 1'b1;
            else if (yumi_i)  full_d = 1'b0;
        end

        // Full flag register.
        always_ff @(posedge clk_i) begin
            if (reset_i) full_q <= 1'b0;
            else         full_q <= full_d;
        end

        assign ready_o = ~full_q;
        assign valid_o = full_q;
    end

`ifndef SYNTHESIS
    // Consumer must not take data that is not being offered.
    always_ff @(posedge clk_i) begin
        if (!reset_i && yumi_i) assert (valid_o);
    end
`endif

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_full.sv
// Directed bench: five instances cover lo/hi ordering, both buffering modes
// and the single-element case. Inputs change 1 time unit after the rising
// edge; outputs are sampled at that same point, before the next edge.
module tb_bsg_serial_in_parallel_out_full;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v  [5];
    logic        y  [5];
    logic [7:0]  di [5];
    logic        r  [5];
    logic        vo [5];
    logic [31:0] dq [3];
    logic [7:0]  ds [2];

    int checks   = 0;
    int failures = 0;

    // 0: mode 0 lo2hi, 1: mode 0 hi2lo, 2: mode 1 lo2hi (els_p=4)
    bsg_serial_in_parallel_out_full #(.width_p(8), .els_p(4), .hi_to_lo_p(0), .use_minimal_buffering_p(0)) dut_lo (
        .clk_i(clk), .reset_i(rst), .valid_i(v[0]), .data_i(di[0]), .ready_o(r[0]),
        .valid_o(vo[0]), .data_o(dq[0]), .yumi_i(y[0]));
    bsg_serial_in_parallel_out_full #(.width_p(8), .els_p(4), .hi_to_lo_p(1), .use_minimal_buffering_p(0)) dut_hi (
        .clk_i(clk), .reset_i(rst), .valid_i(v[1]), .data_i(di[1]), .ready_o(r[1]),
        .valid_o(vo[1]), .data_o(dq[1]), .yumi_i(y[1]));
    bsg_serial_in_parallel_out_full #(.width_p(8), .els_p(4), .hi_to_lo_p(0), .use_minimal_buffering_p(1)) dut_min (
        .clk_i(clk), .reset_i(rst), .valid_i(v[2]), .data_i(di[2]), .ready_o(r[2]),
        .valid_o(vo[2]), .data_o(dq[2]), .yumi_i(y[2]));
    // 3: els_p=1 mode 0, 4: els_p=1 mode 1
    bsg_serial_in_parallel_out_full #(.width_p(8), .els_p(1), .hi_to_lo_p(0), .use_minimal_buffering_p(0)) dut_one0 (
        .clk_i(clk), .reset_i(rst), .valid_i(v[3]), .data_i(di[3]), .ready_o(r[3]),
        .valid_o(vo[3]), .data_o(ds[0]), .yumi_i(y[3]));
    bsg_serial_in_parallel_out_full #(.width_p(8), .els_p(1), .hi_to_lo_p(0), .use_minimal_buffering_p(1)) dut_one1 (
        .clk_i(clk), .reset_i(rst), .valid_i(v[4]), .data_i(di[4]), .ready_o(r[4]),
        .valid_o(vo[4]), .data_o(ds[1]), .yumi_i(y[4]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 5; d++) begin
            v[d] = 1'b0; y[d] = 1'b0; di[d] = 8'h00;
        end
        repeat (3) tick();
        rst = 1'b0;
        for (int d = 0; d < 5; d++) begin
            checks++;
            if (vo[d] !== 1'b0) begin
                failures++; $display("FAIL reset_valid dut%0d: got %b expected 0", d, vo[d]);
            end
            checks++;
            if (r[d] !== 1'b1) begin
                failures++; $display("FAIL reset_ready dut%0d: got %b expected 1", d, r[d]);
            end
        end
    endtask

    // 0x11..0x44 back-to-back with yumi following valid_o.
    task automatic test_order(input int d, input logic [31:0] exp);
        logic [7:0] w [4];
        w = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (r[d] !== 1'b1) begin
                failures++; $display("FAIL order_ready dut%0d c%0d: got %b expected 1", d, c, r[d]);
            end
            checks++;
            if (vo[d] !== (c == 4)) begin
                failures++; $display("FAIL order_valid dut%0d c%0d: got %b expected %b", d, c, vo[d], (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (dq[d] !== exp) begin
                    failures++; $display("FAIL order_data dut%0d: got %h expected %h", d, dq[d], exp);
                end
            end
            v[d]  = (c < 4);
            di[d] = 8'h00;
            if (c < 4) di[d] = w[c];
            y[d]  = (c == 4);
            tick();
        end
        v[d] = 1'b0; y[d] = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] w [7];
        w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (r[0] !== 1'b1) begin
                failures++; $display("FAIL bp_ready c%0d: got %b expected 1", c, r[0]);
            end
            if (c >= 4) begin
                checks++;
                if (vo[0] !== 1'b1 || dq[0] !== 32'h44332211) begin
                    failures++; $display("FAIL bp_hold c%0d: got valid %b data %h expected 1 44332211", c, vo[0], dq[0]);
                end
            end
            v[0] = 1'b1; di[0] = w[c]; y[0] = 1'b0;
            tick();
        end
        // count_r is 3 with the output buffer full: input must stall.
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (r[0] !== 1'b0 || vo[0] !== 1'b1 || dq[0] !== 32'h44332211) begin
                failures++; $display("FAIL bp_stall c%0d: got ready %b valid %b data %h expected 0 1 44332211", c, r[0], vo[0], dq[0]);
            end
            v[0] = 1'b1; di[0] = 8'h88;
            tick();
        end
        y[0] = 1'b1;
        tick();
        y[0] = 1'b0;
        checks++;
        if (r[0] !== 1'b1 || vo[0] !== 1'b0) begin
            failures++; $display("FAIL bp_release: got ready %b valid %b expected 1 0", r[0], vo[0]);
        end
        tick();
        v[0] = 1'b0;
        checks++;
        if (vo[0] !== 1'b1 || dq[0] !== 32'h88776655) begin
            failures++; $display("FAIL bp_second: got valid %b data %h expected 1 88776655", vo[0], dq[0]);
        end
        y[0] = 1'b1;
        tick();
        y[0] = 1'b0;
        checks++;
        if (vo[0] !== 1'b0) begin
            failures++; $display("FAIL bp_drain: got valid %b expected 0", vo[0]);
        end
    endtask

    // 12 words at one per cycle, yumi on every valid cycle: ready must never drop.
    task automatic test_back_to_back();
        logic        exp_vo;
        logic [31:0] exp;
        for (int c = 0; c < 13; c++) begin
            exp_vo = (c >= 4) && (c % 4 == 0);
            checks++;
            if (r[0] !== 1'b1) begin
                failures++; $display("FAIL b2b_ready c%0d: got %b expected 1", c, r[0]);
            end
            checks++;
            if (vo[0] !== exp_vo) begin
                failures++; $display("FAIL b2b_valid c%0d: got %b expected %b", c, vo[0], exp_vo);
            end
            if (exp_vo) begin
                for (int k = 0; k < 4; k++) exp[k*8 +: 8] = 8'(8'h30 + c - 4 + k);
                checks++;
                if (dq[0] !== exp) begin
                    failures++; $display("FAIL b2b_data c%0d: got %h expected %h", c, dq[0], exp);
                end
            end
            v[0]  = (c < 12);
            di[0] = 8'(8'h30 + c);
            y[0]  = exp_vo;
            tick();
        end
        v[0] = 1'b0; y[0] = 1'b0;
        checks++;
        if (vo[0] !== 1'b0) begin
            failures++; $display("FAIL b2b_drain: got %b expected 0", vo[0]);
        end
    endtask

    task automatic test_reset_mid();
        v[0] = 1'b1; di[0] = 8'hAA; tick();
        di[0] = 8'hBB; tick();
        v[0] = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (vo[0] !== 1'b0 || r[0] !== 1'b1) begin
            failures++; $display("FAIL rstmid_state: got valid %b ready %b expected 0 1", vo[0], r[0]);
        end
        for (int c = 0; c < 4; c++) begin
            v[0] = 1'b1; di[0] = 8'(c + 1);
            tick();
        end
        v[0] = 1'b0;
        checks++;
        if (vo[0] !== 1'b1 || dq[0] !== 32'h04030201) begin
            failures++; $display("FAIL rstmid_data: got valid %b data %h expected 1 04030201", vo[0], dq[0]);
        end
        y[0] = 1'b1; tick(); y[0] = 1'b0;
    endtask

    task automatic test_mode1();
        logic [7:0] w [4];
        w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (r[2] !== 1'b1 || vo[2] !== 1'b0) begin
                failures++; $display("FAIL m1_fill c%0d: got ready %b valid %b expected 1 0", c, r[2], vo[2]);
            end
            v[2] = 1'b1; di[2] = w[c];
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (vo[2] !== 1'b1 || r[2] !== 1'b0 || dq[2] !== 32'hD4C3B2A1) begin
                failures++; $display("FAIL m1_full c%0d: got valid %b ready %b data %h expected 1 0 d4c3b2a1", c, vo[2], r[2], dq[2]);
            end
            v[2] = 1'b1; di[2] = 8'hEE;
            if (c < 2) tick();
        end
        v[2] = 1'b0; y[2] = 1'b1;
        tick();
        y[2] = 1'b0;
        checks++;
        if (vo[2] !== 1'b0 || r[2] !== 1'b1) begin
            failures++; $display("FAIL m1_release: got valid %b ready %b expected 0 1", vo[2], r[2]);
        end
        for (int c = 0; c < 4; c++) begin
            v[2] = 1'b1; di[2] = 8'(8'h10 * (c + 1));
            tick();
        end
        v[2] = 1'b0;
        checks++;
        if (vo[2] !== 1'b1 || dq[2] !== 32'h40302010) begin
            failures++; $display("FAIL m1_second: got valid %b data %h expected 1 40302010", vo[2], dq[2]);
        end
        y[2] = 1'b1; tick(); y[2] = 1'b0;
        checks++;
        if (vo[2] !== 1'b0) begin
            failures++; $display("FAIL m1_drain: got %b expected 0", vo[2]);
        end
    endtask

    task automatic test_els1();
        logic       exp_full;
        logic [7:0] n_sent, n_got;
        for (int d = 3; d < 5; d++) begin
            checks++;
            if (r[d] !== 1'b1) begin
                failures++; $display("FAIL one_ready dut%0d: got %b expected 1", d, r[d]);
            end
            v[d] = 1'b1; di[d] = 8'h5A;
        end
        tick();
        v[3] = 1'b0; v[4] = 1'b0;
        for (int d = 3; d < 5; d++) begin
            checks++;
            if (vo[d] !== 1'b1 || ds[d-3] !== 8'h5A || r[d] !== 1'b0) begin
                failures++; $display("FAIL one_vec dut%0d: got valid %b data %h ready %b expected 1 5a 0", d, vo[d], ds[d-3], r[d]);
            end
            y[d] = 1'b1;
        end
        tick();
        y[3] = 1'b0; y[4] = 1'b0;
        for (int d = 3; d < 5; d++) begin
            checks++;
            if (vo[d] !== 1'b0 || r[d] !== 1'b1) begin
                failures++; $display("FAIL one_drain dut%0d: got valid %b ready %b expected 0 1", d, vo[d], r[d]);
            end
        end
        // Streaming with yumi whenever valid: each word delivered in order.
        exp_full = 1'b0; n_sent = 8'h60; n_got = 8'h60;
        for (int c = 0; c < 16; c++) begin
            for (int d = 3; d < 5; d++) begin
                checks++;
                if (vo[d] !== exp_full || r[d] !== !exp_full) begin
                    failures++; $display("FAIL one_stream_hs dut%0d c%0d: got valid %b ready %b expected %b %b", d, c, vo[d], r[d], exp_full, !exp_full);
                end
                if (exp_full) begin
                    checks++;
                    if (ds[d-3] !== n_got) begin
                        failures++; $display("FAIL one_stream_data dut%0d c%0d: got %h expected %h", d, c, ds[d-3], n_got);
                    end
                end
                y[d] = exp_full; v[d] = !exp_full; di[d] = n_sent;
            end
            tick();
            if (exp_full) begin
                exp_full = 1'b0; n_got = n_got + 8'h01;
            end else begin
                exp_full = 1'b1; n_sent = n_sent + 8'h01;
            end
        end
        for (int d = 3; d < 5; d++) begin
            v[d] = 1'b0; y[d] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_order(0, 32'h44332211);
        test_order(1, 32'h11223344);
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_mode1();
        test_els1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
